// File: rtl/simon_pkg.sv
// simon_pkg: state encoding, colour names and helpers shared by simon_engine and simon_lfsr.
package simon_pkg;

  typedef enum logic [2:0] {IDLE, EXTEND, PLAY_ON, PLAY_OFF, INPUT, LOSE, WIN} simon_state_t;

  typedef enum logic [1:0] {GREEN = 2'd0, RED = 2'd1, YELLOW = 2'd2, BLUE = 2'd3} simon_color_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Right-shifting Galois feedback masks giving a maximal-length sequence per width
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       return 32'h3;
      3:       return 32'h6;
      4:       return 32'hC;
      5:       return 32'h14;
      6:       return 32'h30;
      7:       return 32'h60;
      8:       return 32'hB8;
      9:       return 32'h110;
      10:      return 32'h240;
      11:      return 32'h500;
      12:      return 32'hE08;
      13:      return 32'h1C80;
      14:      return 32'h3802;
      15:      return 32'h6000;
      16:      return 32'hB400;
      17:      return 32'h12000;
      18:      return 32'h20400;
      19:      return 32'h72000;
      20:      return 32'h90000;
      24:      return 32'hE10000;
      32:      return 32'hA3000000;
      default: return 32'hB400;
    endcase
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// simon_lfsr: free-running Galois LFSR, loads SEED on synchronous active-low reset.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(1)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  always_ff @(posedge clk)
    q <= !rst_n ? SEED : (q >> 1) ^ (q[0] ? TAPS : '0);

endmodule

// File: rtl/simon_engine.sv
// simon_engine: Simon game engine - sequence store, timed lamp playback, key checking, BCD scores.
// Define SIMON_INPUT_TIMEOUT_EN to make an idle INPUT phase of TIMEOUT_TICKS cycles lose the game.
module simon_engine
  import simon_pkg::*;
#(
  parameter int NUM_COLORS    = 4,
  parameter int MAX_LEN       = 99,
  parameter int LFSR_W        = 16,
  parameter int DISP_TICKS    = 25_000_000,
  parameter int GAP_TICKS     = 10_000_000,
  parameter int TIMEOUT_TICKS = 250_000_000,
  localparam int CW = $clog2(NUM_COLORS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          key_valid,
  input  logic [CW-1:0] key_code,
  output logic          lamp_valid,
  output logic [CW-1:0] lamp_color,
  output logic          awaiting_input,
  output logic          game_over,
  output logic          game_won,
  output logic [7:0]    score_bcd,
  output logic [7:0]    best_bcd
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int PMAX = DISP_TICKS > GAP_TICKS ? DISP_TICKS : GAP_TICKS;
`ifdef SIMON_INPUT_TIMEOUT_EN
  localparam int TMAX = TIMEOUT_TICKS > PMAX ? TIMEOUT_TICKS : PMAX;
`else
  localparam int TMAX = PMAX;
`endif
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [CW:0] NC = (CW + 1)'(NUM_COLORS);

  if (NUM_COLORS < 2 || NUM_COLORS > 8 || MAX_LEN < 1 || MAX_LEN > 99 || DISP_TICKS < 1 ||
      GAP_TICKS < 1 || TIMEOUT_TICKS < 1 || LFSR_W <= CW || LFSR_W > 32) begin : g_param_check
    $error("simon_engine: parameter out of range");
  end

  simon_state_t state, state_d;
  logic [IW-1:0] len, idx, idx_inc;
  logic [TW-1:0] tick;
  logic [CW-1:0] mem [MAX_LEN];
  logic [CW-1:0] new_color, cur_color;
  logic [CW:0] r;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-CW-1:0] lfsr_unused;
  logic key_ok, key_hit, last_key, on_done, off_done, timeout, tick_run, start_ok;

  simon_lfsr #(.LFSR_W(LFSR_W), .SEED(LFSR_W'(1))) u_lfsr (
    .clk(clk),
    .rst_n(rst_n),
    .q(lfsr_q)
  );

  // Only the low CW bits feed the colour; folding keeps non-power-of-two palettes in range
  assign lfsr_unused = lfsr_q[LFSR_W-1:CW];
  assign r = {1'b0, lfsr_q[CW-1:0]};
  assign new_color = r >= NC ? CW'(r - NC) : r[CW-1:0];
  assign cur_color = mem[idx];
  assign idx_inc = idx + 1'b1;
  assign key_ok = key_valid && {1'b0, key_code} < NC;
  assign key_hit = key_ok && key_code == cur_color;
  assign last_key = idx_inc == len;
  assign on_done = tick == TW'(DISP_TICKS - 1);
  assign off_done = tick == TW'(GAP_TICKS - 1);
  assign start_ok = start && (state == IDLE || state == LOSE || state == WIN);
`ifdef SIMON_INPUT_TIMEOUT_EN
  assign timeout = tick == TW'(TIMEOUT_TICKS - 1);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state;
    tick_run = 1'b0;
    case (state)
      IDLE, LOSE, WIN: state_d = start ? EXTEND : state;
      EXTEND:          state_d = PLAY_ON;
      PLAY_ON: begin
        state_d = on_done ? PLAY_OFF : PLAY_ON;
        tick_run = 1'b1;
      end
      PLAY_OFF: begin
        state_d = !off_done ? PLAY_OFF : last_key ? INPUT : PLAY_ON;
        tick_run = 1'b1;
      end
      INPUT: begin
        state_d = key_ok ? (!key_hit ? LOSE : !last_key ? INPUT : len == IW'(MAX_LEN) ? WIN : EXTEND)
                         : timeout ? LOSE : INPUT;
`ifdef SIMON_INPUT_TIMEOUT_EN
        tick_run = !key_hit;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_d;

  // The tick counter restarts on every state change, so each phase times itself from zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len <= '0;
      idx <= '0;
      tick <= '0;
      score_bcd <= '0;
      best_bcd <= '0;
    end else begin
      tick <= tick_run && state_d == state ? tick + 1'b1 : '0;
      if (start_ok) begin
        len <= '0;
        score_bcd <= '0;
      end
      if (state == EXTEND) begin
        len <= len + 1'b1;
        idx <= '0;
      end
      if (state == PLAY_OFF && off_done) idx <= last_key ? '0 : idx_inc;
      if (state == INPUT && key_hit) idx <= idx_inc;
      if (state == INPUT && key_hit && last_key) score_bcd <= bcd_inc(score_bcd);
      if ((state == LOSE || state == WIN) && score_bcd > best_bcd) best_bcd <= score_bcd;
    end
  end

  always_ff @(posedge clk)
    if (rst_n && state == EXTEND) mem[len] <= new_color;

  assign lamp_valid = state == PLAY_ON;
  assign lamp_color = lamp_valid ? cur_color : '0;
  assign awaiting_input = state == INPUT;
  assign game_over = state == LOSE;
  assign game_won = state == WIN;

endmodule

// File: tb/tb_simon_engine.sv
// tb_simon_engine: scoreboard bench for simon_engine; stimulus queues expected output changes, monitor checks them.
module tb_simon_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic key_valid = 1'b0;
  logic [1:0] key_code = 2'd0;
  logic lamp_valid, awaiting_input, game_over, game_won;
  logic [1:0] lamp_color;
  logic [7:0] score_bcd, best_bcd;

  simon_engine #(
    .NUM_COLORS(4), .MAX_LEN(3), .LFSR_W(16), .DISP_TICKS(4), .GAP_TICKS(2), .TIMEOUT_TICKS(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_valid(key_valid), .key_code(key_code),
    .lamp_valid(lamp_valid), .lamp_color(lamp_color), .awaiting_input(awaiting_input),
    .game_over(game_over), .game_won(game_won), .score_bcd(score_bcd), .best_bcd(best_bcd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int at;
    int pos;
    logic learn;
    logic lv, aw, go, gw;
    logic [7:0] sc, be;
  } exp_t;

  exp_t q[$];
  logic [1:0] seq [3];
  int total = 0;
  int bad = 0;
  logic [7:0] esc = 8'h00;
  logic [7:0] ebe = 8'h00;
  logic mon_en = 1'b0;
  int input_at = 0;

  // Every change of the observable tuple must match the next queued expectation, at its cycle
  always @(negedge clk) begin : mon
    logic [21:0] obs, want;
    logic [21:0] prev_obs;
    exp_t e;
    logic [1:0] ec;
    obs = {lamp_valid, lamp_color, awaiting_input, game_over, game_won, score_bcd, best_bcd};
    if (mon_en && obs !== prev_obs) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change: cyc=%0d got=%h", cyc, obs);
      end else begin
        e = q.pop_front();
        if (e.lv && e.learn) seq[e.pos] = lamp_color;
        ec = e.lv ? seq[e.pos] : 2'd0;
        want = {e.lv, ec, e.aw, e.go, e.gw, e.sc, e.be};
        if (obs !== want || cyc != e.at) begin
          bad++;
          $display("FAIL %s: got=%h at cyc %0d, required=%h at cyc %0d", e.name, obs, cyc, want, e.at);
        end
      end
    end else if (mon_en && q.size() > 0 && cyc > q[0].at) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: no change by cyc %0d, required at cyc %0d", e.name, cyc, e.at);
    end
    prev_obs = obs;
  end

  task automatic push(input string n, input int at, input int pos, input logic learn,
                      input logic lv, input logic aw, input logic go, input logic gw);
    exp_t e;
    e.name = n; e.at = at; e.pos = pos; e.learn = learn;
    e.lv = lv; e.aw = aw; e.go = go; e.gw = gw; e.sc = esc; e.be = ebe;
    q.push_back(e);
  endtask

  // Round k playback after the engine is in EXTEND following edge ext
  task automatic push_play(input int k, input int ext);
    for (int i = 0; i < k; i++) begin
      push($sformatf("r%0d_lamp%0d_on", k, i), ext + 1 + 6 * i, i, i == k - 1, 1'b1, 1'b0, 1'b0, 1'b0);
      push($sformatf("r%0d_lamp%0d_off", k, i), ext + 5 + 6 * i, i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    input_at = ext + 1 + 6 * k;
    push($sformatf("r%0d_input", k), input_at, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_start(input logic clears, input logic full_play);
    int n;
    n = cyc + 1;
    start = 1'b1;
    esc = 8'h00;
    if (clears) push("start_clear", n, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (full_play) push_play(1, n);
    else push("r1_lamp0_on", n + 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [1:0] c, input int round, input logic last, input logic wrong);
    int m;
    m = cyc + 1;
    key_valid = 1'b1;
    key_code = c;
    if (wrong || (last && round == 3)) begin
      if (!wrong) esc = esc + 8'h01;
      push(wrong ? "lose" : "win", m, 0, 1'b0, 1'b0, 1'b0, wrong, !wrong);
      if (esc > ebe) begin
        ebe = esc;
        push("best_update", m + 1, 0, 1'b0, 1'b0, 1'b0, wrong, !wrong);
      end
    end else if (last) begin
      esc = esc + 8'h01;
      push($sformatf("score_r%0d", round), m, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push_play(round + 1, m);
    end
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic play_round(input int k);
    for (int i = 0; i < k; i++) press(seq[i], k, i == k - 1, 1'b0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations outstanding after %0d cycles, required 0", q.size(), budget);
      q.delete();
    end
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", n, got, want);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {10'd0, lamp_valid, lamp_color, awaiting_input, game_over, game_won, score_bcd, best_bcd}, 32'd0);
    mon_en = 1'b1;
    // Game 1: ignored key during playback, ignored start in INPUT, then a full win
    do_start(1'b0, 1'b1);
    @(negedge clk);
    key_valid = 1'b1;
    key_code = 2'd3;
    @(negedge clk);
    key_valid = 1'b0;
    drain(100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    play_round(1);
    start = 1'b0;
    drain(100);
    play_round(2);
    drain(100);
    play_round(3);
    drain(100);
    // Game 2: wrong first key in round 2 loses with score 1, best stays 3
    do_start(1'b1, 1'b1);
    drain(100);
    play_round(1);
    drain(100);
    press(seq[0] ^ 2'd1, 2, 1'b0, 1'b1);
    drain(100);
    repeat (5) @(negedge clk);
    // Game 3: reset in the middle of the first lamp clears everything, best included
    do_start(1'b1, 1'b0);
    drain(100);
    @(negedge clk);
    rst_n = 1'b0;
    esc = 8'h00;
    ebe = 8'h00;
    push("mid_play_reset", cyc + 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain(100);
    repeat (3) @(negedge clk);
    // Game 4: no key at all in INPUT
    do_start(1'b0, 1'b1);
    drain(100);
`ifdef SIMON_INPUT_TIMEOUT_EN
    push("timeout_lose", input_at + 20, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(100);
`else
    repeat (1000) @(negedge clk);
    chk("no_timeout_still_input", {31'd0, awaiting_input}, 32'd1);
`endif
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish by time limit");
    $fatal(1);
  end

endmodule
